// File: rtl/fixed_activation_lut_writer_pkg.sv
// Shared types and sizing helpers for the runtime-loaded LUT activation.
// The FIXED_LUT_RELOAD_EN build makes the DRAIN state reachable.
package fixed_lut_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    function automatic int lut_depth(input int in_w);
        return 1 << in_w;
    endfunction

    function automatic int lut_lanes(input int dim_0, input int dim_1);
        return dim_0 * dim_1;
    endfunction

endpackage

// File: rtl/fixed_activation_lut_writer_if.sv
// Config stream plus lookup/result handshakes of the LUT activation.
// The cfg_reload member exists only when FIXED_LUT_RELOAD_EN is defined.
interface fixed_activation_lut_writer_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int LANES = 1
);
    logic [OUT_W-1:0]            cfg_data;
    logic                        cfg_valid;
    logic                        cfg_ready;
`ifdef FIXED_LUT_RELOAD_EN
    logic                        cfg_reload;
`endif
    logic                        table_loaded;
    logic [LANES-1:0][IN_W-1:0]  data_in_0;
    logic                        data_in_0_valid;
    logic                        data_in_0_ready;
    logic [LANES-1:0][OUT_W-1:0] data_out_0;
    logic                        data_out_0_valid;
    logic                        data_out_0_ready;

    modport master (
`ifdef FIXED_LUT_RELOAD_EN
        output cfg_reload,
`endif
        output cfg_data, cfg_valid, data_in_0, data_in_0_valid, data_out_0_ready,
        input  cfg_ready, table_loaded, data_in_0_ready, data_out_0, data_out_0_valid
    );

    modport slave (
`ifdef FIXED_LUT_RELOAD_EN
        input  cfg_reload,
`endif
        input  cfg_data, cfg_valid, data_in_0, data_in_0_valid, data_out_0_ready,
        output cfg_ready, table_loaded, data_in_0_ready, data_out_0, data_out_0_valid
    );
endinterface

// File: rtl/fixed_activation_lut_writer_storage.sv
// Table storage: DEPTH x DATA_W array, one synchronous write port and
// LANES asynchronous read ports.
module fixed_lut_storage
    import fixed_lut_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LANES  = 1
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [LANES-1:0][ADDR_W-1:0] raddr,
    output logic [LANES-1:0][DATA_W-1:0] rdata
);
    localparam int DEPTH = lut_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the FSM guarantees every entry is
    // rewritten before any read is allowed, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_rd
        assign rdata[i] = mem[raddr[i]];
    end
endmodule

// File: rtl/fixed_activation_lut_writer.sv
// LUT activation whose table is streamed in over cfg after reset.
// Define FIXED_LUT_RELOAD_EN to add cfg_reload and the DRAIN state.
module fixed_activation_lut_writer
    import fixed_lut_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4
) (
    input logic clk,
    input logic rst,
    fixed_activation_lut_writer_if.slave bus
);
    localparam int IN_W  = DATA_IN_0_PRECISION_0;
    localparam int OUT_W = DATA_OUT_0_PRECISION_0;
    localparam int LANES = lut_lanes(DATA_IN_0_PARALLELISM_DIM_0, DATA_IN_0_PARALLELISM_DIM_1);
    localparam int DEPTH = lut_depth(IN_W);

    // Fractional widths are metadata; only reject nonsensical combinations.
    if (DATA_IN_0_PRECISION_1 > IN_W || DATA_OUT_0_PRECISION_1 > OUT_W) begin : g_bad_frac
        $error("fractional bits exceed word width");
    end

    state_t                      state_q, state_d;
    logic [IN_W-1:0]             wr_addr_q;
    logic [LANES-1:0][OUT_W-1:0] rd_data;
    logic [LANES-1:0][OUT_W-1:0] out_data_q;
    logic                        out_valid_q;
    logic                        cfg_hs, in_hs, last_beat;

    assign cfg_hs    = bus.cfg_valid && bus.cfg_ready;
    assign in_hs     = bus.data_in_0_valid && bus.data_in_0_ready;
    assign last_beat = (wr_addr_q == IN_W'(DEPTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:   if (cfg_hs && last_beat) state_d = ACTIVE;
`ifdef FIXED_LUT_RELOAD_EN
            ACTIVE: if (bus.cfg_reload) state_d = DRAIN;
            DRAIN:  if (!out_valid_q || bus.data_out_0_ready) state_d = LOAD;
`else
            ACTIVE: state_d = ACTIVE;
`endif
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        bus.cfg_ready       = (state_q == LOAD) && !rst;
        bus.table_loaded    = (state_q == ACTIVE);
        bus.data_in_0_ready = (state_q == ACTIVE) && (!out_valid_q || bus.data_out_0_ready);
    end

    // Wraps to zero on the final beat, ready for the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         wr_addr_q <= '0;
        else if (cfg_hs) wr_addr_q <= wr_addr_q + 1'b1;
    end

    fixed_lut_storage #(
        .ADDR_W (IN_W),
        .DATA_W (OUT_W),
        .LANES  (LANES)
    ) u_storage (
        .clk   (clk),
        .we    (cfg_hs),
        .waddr (wr_addr_q),
        .wdata (bus.cfg_data),
        .raddr (bus.data_in_0),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (in_hs) begin
            out_data_q  <= rd_data;
            out_valid_q <= 1'b1;
        end else if (bus.data_out_0_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.data_out_0       = out_data_q;
    assign bus.data_out_0_valid = out_valid_q;
endmodule

// File: tb/tb_fixed_activation_lut_writer.sv
// Directed bench for fixed_activation_lut_writer with 4 lanes (2x2).
// Reload sequence is compiled only when FIXED_LUT_RELOAD_EN is defined.
module tb_fixed_activation_lut_writer;
    import fixed_lut_pkg::*;

    localparam int IN_W  = 8;
    localparam int OUT_W = 8;
    localparam int LANES = 4;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dexp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fixed_activation_lut_writer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) bus ();

    fixed_activation_lut_writer #(
        .DATA_IN_0_PRECISION_0       (IN_W),
        .DATA_IN_0_PRECISION_1       (4),
        .DATA_IN_0_PARALLELISM_DIM_0 (2),
        .DATA_IN_0_PARALLELISM_DIM_1 (2),
        .DATA_OUT_0_PRECISION_0      (OUT_W),
        .DATA_OUT_0_PRECISION_1      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Streams n table entries starting at index start; entry = ~idx or idx.
    task automatic load_beats(input int start, input int n, input bit inv);
        int not_ready;
        int in_open;
        logic [7:0] v;
        not_ready = 0;
        in_open   = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            v = 8'(start + k);
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = inv ? ~v : v;
            #1;
            if (!bus.cfg_ready)      not_ready++;
            if (bus.data_in_0_ready) in_open++;
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("load_cfg_ready_drops", 32'(not_ready), 32'd0);
        check("load_in_ready_open", 32'(in_open), 32'd0);
    endtask

    vec_t        vecs [6];
    logic [31:0] q [$];
    logic [31:0] cur;
    logic [31:0] exp_word;
    bit          have;
    int          sent, got;

    initial begin
        vecs[0] = '{din: 32'hFF807F00, dexp: 32'h007F80FF};
        vecs[1] = '{din: 32'h05050505, dexp: 32'hFAFAFAFA};
        vecs[2] = '{din: 32'h01234567, dexp: 32'hFEDCBA98};
        vecs[3] = '{din: 32'hA5C33C5A, dexp: 32'h5A3CC3A5};
        vecs[4] = '{din: 32'h10203040, dexp: 32'hEFDFCFBF};
        vecs[5] = '{din: 32'hFFFFFFFF, dexp: 32'h00000000};

        bus.cfg_data         = '0;
        bus.cfg_valid        = 1'b0;
`ifdef FIXED_LUT_RELOAD_EN
        bus.cfg_reload       = 1'b0;
`endif
        bus.data_in_0        = '0;
        bus.data_in_0_valid  = 1'b0;
        bus.data_out_0_ready = 1'b1;

        // Reset values while rst is held
        repeat (2) @(negedge clk);
        #1;
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        check("rst_table_loaded", 32'(bus.table_loaded), 32'd0);
        check("rst_out_valid", 32'(bus.data_out_0_valid), 32'd0);
        check("rst_out_data", bus.data_out_0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("load_cfg_ready", 32'(bus.cfg_ready), 32'd1);

        // Lookup requested throughout the load must wait for the last beat
        bus.data_in_0_valid = 1'b1;
        bus.data_in_0       = 32'h05050505;
        load_beats(0, 256, 1'b1);
        #1;
        check("active_table_loaded", 32'(bus.table_loaded), 32'd1);
        check("active_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        check("active_in_ready", 32'(bus.data_in_0_ready), 32'd1);
        check("first_out_not_early", 32'(bus.data_out_0_valid), 32'd0);
        @(negedge clk);
        bus.data_in_0_valid = 1'b0;
        #1;
        check("first_out_valid", 32'(bus.data_out_0_valid), 32'd1);
        check("first_out_data", bus.data_out_0, 32'hFAFAFAFA);

        // Back-to-back table vectors at full throughput
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (i > 0) begin
                check("vec_valid", 32'(bus.data_out_0_valid), 32'd1);
                check($sformatf("vec%0d_data", i - 1), bus.data_out_0, vecs[i-1].dexp);
            end
            bus.data_in_0_valid = 1'b1;
            bus.data_in_0       = vecs[i].din;
        end
        @(negedge clk);
        #1;
        check("vec5_data", bus.data_out_0, vecs[5].dexp);
        bus.data_in_0_valid = 1'b0;
        @(negedge clk);
        #1;
        check("vec_drained", 32'(bus.data_out_0_valid), 32'd0);

        // Two-cycle output stall holds data and blocks input
        bus.data_in_0_valid  = 1'b1;
        bus.data_in_0        = vecs[2].din;
        bus.data_out_0_ready = 1'b0;
        @(negedge clk);
        bus.data_in_0 = vecs[3].din;
        #1;
        check("stall_valid", 32'(bus.data_out_0_valid), 32'd1);
        check("stall_in_ready", 32'(bus.data_in_0_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("stall_hold_data", bus.data_out_0, vecs[2].dexp);
            check("stall_hold_in_ready", 32'(bus.data_in_0_ready), 32'd0);
        end
        bus.data_out_0_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(bus.data_in_0_ready), 32'd1);
        @(negedge clk);
        bus.data_in_0_valid = 1'b0;
        #1;
        check("release_next_data", bus.data_out_0, vecs[3].dexp);

        // 100-beat stream with random input gaps and output stalls
        have = 1'b0;
        sent = 0;
        got  = 0;
        cur  = '0;
        for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
            @(negedge clk);
            if (!have && sent < 100 && $urandom_range(0, 3) != 0) begin
                have = 1'b1;
                cur  = $urandom;
            end
            bus.data_in_0_valid  = have;
            bus.data_in_0        = cur;
            bus.data_out_0_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.data_out_0_valid && bus.data_out_0_ready) begin
                if (q.size() == 0) begin
                    check("stream_unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_word = q.pop_front();
                    check("stream_data", bus.data_out_0, exp_word);
                end
                got++;
            end
            if (have && bus.data_in_0_ready) begin
                q.push_back(~cur);
                sent++;
                have = 1'b0;
            end
        end
        @(negedge clk);
        bus.data_in_0_valid  = 1'b0;
        bus.data_out_0_ready = 1'b1;
        check("stream_count", 32'(got), 32'd100);
        check("stream_leftover", 32'(q.size()), 32'd0);

`ifdef FIXED_LUT_RELOAD_EN
        // Reload while the output is stalled: DRAIN waits for the result to leave
        @(negedge clk);
        bus.data_in_0_valid  = 1'b1;
        bus.data_in_0        = 32'h05050505;
        bus.data_out_0_ready = 1'b0;
        @(negedge clk);
        bus.data_in_0_valid = 1'b0;
        bus.cfg_reload      = 1'b1;
        @(negedge clk);
        bus.cfg_reload = 1'b0;
        repeat (2) begin
            #1;
            check("drain_table_loaded", 32'(bus.table_loaded), 32'd0);
            check("drain_cfg_ready", 32'(bus.cfg_ready), 32'd0);
            check("drain_in_ready", 32'(bus.data_in_0_ready), 32'd0);
            check("drain_held_data", bus.data_out_0, 32'hFAFAFAFA);
            @(negedge clk);
        end
        bus.data_out_0_ready = 1'b1;
        @(negedge clk);
        #1;
        check("reload_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check("reload_out_valid", 32'(bus.data_out_0_valid), 32'd0);
        load_beats(0, 256, 1'b0);
        #1;
        check("reload_loaded", 32'(bus.table_loaded), 32'd1);
        bus.data_in_0_valid = 1'b1;
        bus.data_in_0       = 32'h05FF8000;
        @(negedge clk);
        bus.data_in_0_valid = 1'b0;
        #1;
        check("identity_data", bus.data_out_0, 32'h05FF8000);
`endif

        // Reset while an output is stalled clears everything at once
        @(negedge clk);
        bus.data_in_0_valid  = 1'b1;
        bus.data_in_0        = vecs[1].din;
        bus.data_out_0_ready = 1'b0;
        @(negedge clk);
        bus.data_in_0_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.data_out_0_valid), 32'd0);
        check("async_rst_data", bus.data_out_0, 32'd0);
        check("async_rst_loaded", 32'(bus.table_loaded), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.data_out_0_ready = 1'b1;

        // Reset after 100 beats: a full 256-beat reload is required
        load_beats(0, 100, 1'b1);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'h9B;
        #2;
        rst = 1'b1;
        #1;
        check("midload_rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.cfg_valid = 1'b0;
        load_beats(0, 255, 1'b1);
        #1;
        check("after_255_not_loaded", 32'(bus.table_loaded), 32'd0);
        load_beats(255, 1, 1'b1);
        #1;
        check("after_256_loaded", 32'(bus.table_loaded), 32'd1);
        bus.data_in_0_valid = 1'b1;
        bus.data_in_0       = vecs[0].din;
        @(negedge clk);
        bus.data_in_0_valid = 1'b0;
        #1;
        check("post_rst_lanes", bus.data_out_0, vecs[0].dexp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
